// File: rtl/assoc_cache.sv
// Two-way set-associative, write-through, no-write-allocate cache with a zero-latency read-hit path.
// Optional hit/miss performance counters are compiled in with CACHE_PERF_CNT_EN.
module assoc_cache #(
  parameter int SET_BITS  = 3,
  parameter int WORD_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS   = 1 << SET_BITS;
  localparam int WORDS  = 1 << WORD_BITS;
  localparam int TAG_W  = 30 - SET_BITS - WORD_BITS;
  localparam int SET_LO = 2 + WORD_BITS;
  localparam int TAG_LO = SET_LO + SET_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0]     req_tag;
  logic [SET_BITS-1:0]  req_set;
  logic [WORD_BITS-1:0] req_word;

  assign req_tag  = req_addr[31:TAG_LO];
  assign req_set  = req_addr[TAG_LO-1:SET_LO];
  assign req_word = req_addr[SET_LO-1:2];

  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tags [2][SETS];
  logic [31:0]      data [2][SETS][WORDS];

  logic [WORD_BITS-1:0] cnt;
  logic                 victim;
  logic                 victim_sel;

  logic hit0, hit1, hit_way;
  logic read_hit, write_hit, start_refill, refill_store, refill_last;

  assign hit0    = valid[0][req_set] && (tags[0][req_set] == req_tag);
  assign hit1    = valid[1][req_set] && (tags[1][req_set] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1 & ~hit0;

  always_comb begin
    rdata = 32'h0;
    if (hit0)
      rdata = data[0][req_set][req_word];
    else if (hit1)
      rdata = data[1][req_set][req_word];
  end

  // Invalid ways are filled before anything valid is evicted, way 0 first.
  always_comb begin
    if (!valid[0][req_set])
      victim_sel = 1'b0;
    else if (!valid[1][req_set])
      victim_sel = 1'b1;
    else
      victim_sel = lru[req_set];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    read_hit     = 1'b0;
    write_hit    = 1'b0;
    start_refill = 1'b0;
    refill_store = 1'b0;
    refill_last  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_we) begin
            if (hit) begin
              req_ready = 1'b1;
              read_hit  = 1'b1;
            end else begin
              start_refill = 1'b1;
              state_nxt    = REFILL;
            end
          end else begin
            write_hit = hit;
            state_nxt = WRITE;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_set, cnt, 2'b00};
        if (mem_ack) begin
          refill_store = 1'b1;
          if (cnt == {WORD_BITS{1'b1}}) begin
            refill_last = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        req_ready = mem_ack;
        if (mem_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The victim is invalidated up front so an interrupted refill never exposes a mixed line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
      cnt      <= '0;
      victim   <= 1'b0;
    end else begin
      if (start_refill) begin
        victim                    <= victim_sel;
        valid[victim_sel][req_set] <= 1'b0;
        cnt                       <= '0;
      end
      if (refill_store)
        cnt <= cnt + 1'b1;
      if (refill_last) begin
        valid[victim][req_set] <= 1'b1;
        lru[req_set]           <= ~victim;
      end
      if (read_hit || write_hit)
        lru[req_set] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_store)
      data[victim][req_set][cnt] <= mem_rdata;
    if (refill_last)
      tags[victim][req_set] <= req_tag;
    if (write_hit)
      data[hit_way][req_set][req_word] <= req_wdata;
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (read_hit && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (start_refill && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: MRU-list cache model plus a backing memory with random ack timing.
module tb_assoc_cache;

  localparam int SB    = 3;
  localparam int WB    = 1;
  localparam int SETS  = 1 << SB;
  localparam int WORDS = 1 << WB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic [31:0] rdata;
  logic        hit;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  assoc_cache #(.SET_BITS(SB), .WORD_BITS(WB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rdata     (rdata),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        we;
    logic        eh;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  op_t exp_ops[$];
  sb_t sb_q[$];
  int  acks_seen = 0;

  // Backing memory: unwritten words read as a unique address-derived pattern.
  logic [31:0] mem [bit [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a))
      return mem[a];
    return 32'hAAAA_0000 + (a - 32'h100);
  endfunction

  // Reference cache: per set, resident tags ordered most-recently-used first.
  int          m_n [SETS];
  logic [31:0] m_t [SETS][2];

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) m_n[s] = 0;
  endfunction

  function automatic logic m_has(input int s, input logic [31:0] t);
    return (m_n[s] > 0 && m_t[s][0] == t) || (m_n[s] > 1 && m_t[s][1] == t);
  endfunction

  function automatic void m_touch(input int s, input logic [31:0] t);
    if (m_t[s][0] != t) begin
      m_t[s][1] = m_t[s][0];
      m_t[s][0] = t;
    end
  endfunction

  function automatic void m_insert(input int s, input logic [31:0] t);
    if (m_n[s] < 2) m_n[s]++;
    m_t[s][1] = m_t[s][0];
    m_t[s][0] = t;
  endfunction

  // Memory responder: random ack timing, spurious acks while idle.
  op_t rop;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && ($urandom_range(0, 1) == 1)) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        acks_seen++;
        if (exp_ops.size() == 0) begin
          chk("unexpected_mem_op", mem_addr, 32'hFFFF_FFFF);
        end else begin
          rop = exp_ops.pop_front();
          chk("mem_we", 32'(mem_we), 32'(rop.we));
          chk("mem_addr", mem_addr, rop.addr);
          if (rop.we) chk("mem_wdata", mem_wdata, rop.wdata);
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else if (!mem_req && ($urandom_range(0, 3) == 0)) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // Completion monitor.
  sb_t me;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && req_valid && req_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", 32'(req_ready), 32'h0);
        end else begin
          me = sb_q.pop_front();
          if (!me.we) begin
            chk("rd_data", rdata, me.data);
            chk("rd_hit", 32'(hit), 32'h1);
            if (me.eh) chk("hit_latency", 32'(cyc - me.cyc), 32'h0);
          end else begin
            chk("wr_hit", 32'(hit), 32'(me.eh));
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
`endif
    m_clear();
    exp_ops.delete();
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic hit_i, output logic [31:0] rd_o);
    int          s;
    int          n;
    logic [31:0] tg;
    logic        eh;
    logic [31:0] d;
    op_t         o;
    sb_t         e;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    s  = int'((addr >> 3) & 32'h7);
    tg = addr >> 6;
    eh = m_has(s, tg);
    d  = mem_rd(addr);
    if (we) begin
      o.we = 1'b1; o.addr = addr; o.wdata = wdata;
      exp_ops.push_back(o);
    end else if (!eh) begin
      for (int w = 0; w < WORDS; w++) begin
        o.we = 1'b0; o.addr = (addr & ~32'h7) + 32'(w * 4); o.wdata = 32'h0;
        exp_ops.push_back(o);
      end
    end
    e.we = we; e.eh = eh; e.data = d; e.cyc = cyc;
    sb_q.push_back(e);
    if (eh) m_touch(s, tg);
    else if (!we) m_insert(s, tg);
    @(negedge clk);
    #2;
    hit_i = hit;
    chk("issue_hit", 32'(hit), 32'(eh));
    chk("issue_rdata", rdata, eh ? d : 32'h0);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!req_ready) begin
      $display("FAIL req_ready_timeout addr %h: got 0 required 1", addr);
      $fatal(1, "request never completed");
    end
    rd_o = rdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  logic        h;
  logic [31:0] r;
  int          n0;
  int          a0;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    m_clear();
    do_reset();

    // Refill then hit on the other word of the line.
    do_req(1'b0, 32'h100, 32'h0, h, r);
    chk("r020_miss", 32'(h), 32'h0);
    chk("r020_data0", r, 32'hAAAA_0000);
    do_req(1'b0, 32'h104, 32'h0, h, r);
    chk("r020_hit", 32'(h), 32'h1);
    chk("r020_data1", r, 32'hAAAA_0004);
`ifdef CACHE_PERF_CNT_EN
    chk("perf_hit_count", hit_count, 32'd2);
    chk("perf_miss_count", miss_count, 32'd1);
`endif

    // Write-through on hit.
    do_req(1'b1, 32'h104, 32'h1234_5678, h, r);
    do_req(1'b0, 32'h104, 32'h0, h, r);
    chk("r022_hit", 32'(h), 32'h1);
    chk("r022_data", r, 32'h1234_5678);

    // LRU eviction in set 0.
    do_req(1'b0, 32'h100, 32'h0, h, r);
    do_req(1'b0, 32'h140, 32'h0, h, r);
    do_req(1'b0, 32'h100, 32'h0, h, r);
    do_req(1'b0, 32'h180, 32'h0, h, r);
    chk("r021_180_miss", 32'(h), 32'h0);
    do_req(1'b0, 32'h100, 32'h0, h, r);
    chk("r021_100_hit", 32'(h), 32'h1);
    do_req(1'b0, 32'h140, 32'h0, h, r);
    chk("r021_140_miss", 32'(h), 32'h0);

    // No allocate on write miss.
    do_req(1'b1, 32'h200, 32'hCAFE_0200, h, r);
    chk("r023_wmiss", 32'(h), 32'h0);
    do_req(1'b0, 32'h200, 32'h0, h, r);
    chk("r023_rmiss", 32'(h), 32'h0);
    chk("r023_data", r, 32'hCAFE_0200);

    // Reset in the middle of a refill.
    do_reset();
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    begin
      op_t o;
      for (int w = 0; w < WORDS; w++) begin
        o.we = 1'b0; o.addr = 32'h100 + 32'(w * 4); o.wdata = 32'h0;
        exp_ops.push_back(o);
      end
    end
    a0 = acks_seen;
    n0 = 0;
    while (acks_seen == a0 && n0 < 200) begin
      @(negedge clk);
      #2;
      n0++;
    end
    if (acks_seen == a0) begin
      $display("FAIL refill_ack_timeout: got 0 acks required 1");
      $fatal(1, "no refill ack");
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("r024_mem_req", 32'(mem_req), 32'h0);
    chk("r024_mem_addr", mem_addr, 32'h0);
    chk("r024_req_ready", 32'(req_ready), 32'h0);
    exp_ops.delete();
    sb_q.delete();
    m_clear();
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(1'b0, 32'h100, 32'h0, h, r);
    chk("r024_after_miss", 32'(h), 32'h0);

    // Random traffic over two sets and four tags to force evictions.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic        w;
      a = (32'($urandom_range(4, 7)) << 6) | (32'($urandom_range(0, 1)) << 3)
        | (32'($urandom_range(0, 1)) << 2);
      w = ($urandom_range(0, 9) < 3);
      do_req(w, a, $urandom, h, r);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("ops_drained", 32'(exp_ops.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
